// File: rtl/regfile.sv
// 32x32 register file with combinational read ports and an issue scoreboard
// that flags registers with an in-flight producer. Define REGFILE_BYPASS_EN to forward write-back data.
module regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_waddr,
    output logic              busy1_o,
    output logic              busy2_o,
    output logic [ADDR_W:0]   pend_cnt_o
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_W-1:0]   mem [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;
    logic [ADDR_W:0]     cnt_next;
    logic                set_any;
    logic                clr_any;
    logic                inc;
    logic                dec;
    logic                hit1;
    logic                hit2;

    assign set_any = issue_we && (issue_waddr != '0);
    assign clr_any = we && (waddr != '0);

    assign hit1 = BYPASS && clr_any && (waddr == raddr1);
    assign hit2 = BYPASS && clr_any && (waddr == raddr2);

    assign rdata1 = (rst || !re1 || raddr1 == '0) ? '0 :
                    hit1 ? wdata : mem[raddr1];
    assign rdata2 = (rst || !re2 || raddr2 == '0) ? '0 :
                    hit2 ? wdata : mem[raddr2];

    // Busy reflects registered pending state only; a same-cycle issue does not show up
    assign busy1_o = !rst && re1 && (raddr1 != '0) && pending[raddr1] && !hit1;
    assign busy2_o = !rst && re2 && (raddr2 != '0) && pending[raddr2] && !hit2;

    // Set is applied after clear so a newer producer of the same register wins
    always_comb begin
        pending_next = pending;
        if (clr_any) pending_next[waddr] = 1'b0;
        if (set_any) pending_next[issue_waddr] = 1'b1;
    end

    // At most one bit rises and one bit falls per cycle, so the count moves by -1, 0 or +1
    assign inc = set_any && !pending[issue_waddr];
    assign dec = clr_any && pending[waddr] && !(set_any && issue_waddr == waddr);

    always_comb begin
        cnt_next = pend_cnt_o;
        if (inc && !dec)      cnt_next = pend_cnt_o + (ADDR_W+1)'(1);
        else if (dec && !inc) cnt_next = pend_cnt_o - (ADDR_W+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
            pending    <= '0;
            pend_cnt_o <= '0;
        end else begin
            if (clr_any) mem[waddr] <= wdata;
            pending    <= pending_next;
            pend_cnt_o <= cnt_next;
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: a directed vector table followed by
// hand-written fill/drain sequences exercising the scoreboard counter range.
module tb_regfile;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        issue_we;
    logic [4:0]  issue_waddr;
    logic        busy1_o;
    logic        busy2_o;
    logic [5:0]  pend_cnt_o;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        bit          rst;
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          re1;
        logic [4:0]  ra1;
        bit          re2;
        logic [4:0]  ra2;
        bit          iwe;
        logic [4:0]  iwa;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        bit          e_b1;
        bit          e_b2;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    regfile dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .issue_we(issue_we), .issue_waddr(issue_waddr),
        .busy1_o(busy1_o), .busy2_o(busy2_o), .pend_cnt_o(pend_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit r, bit w, logic [4:0] wa, logic [31:0] wd,
                                bit e1, logic [4:0] a1, bit e2, logic [4:0] a2,
                                bit iw, logic [4:0] ia,
                                logic [31:0] x1, logic [31:0] x2, bit b1, bit b2,
                                logic [5:0] c);
        vec_t v;
        v.rst = r; v.we = w; v.wa = wa; v.wd = wd;
        v.re1 = e1; v.ra1 = a1; v.re2 = e2; v.ra2 = a2;
        v.iwe = iw; v.iwa = ia;
        v.e_rd1 = x1; v.e_rd2 = x2; v.e_b1 = b1; v.e_b2 = b2; v.e_cnt = c;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst = v.rst; we = v.we; waddr = v.wa; wdata = v.wd;
        re1 = v.re1; raddr1 = v.ra1; re2 = v.re2; raddr2 = v.ra2;
        issue_we = v.iwe; issue_waddr = v.iwa;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkVec(input int idx, input vec_t v);
        checkOutput($sformatf("v%0d rdata1", idx), rdata1, v.e_rd1);
        checkOutput($sformatf("v%0d rdata2", idx), rdata2, v.e_rd2);
        checkOutput($sformatf("v%0d busy1", idx), {31'b0, busy1_o}, {31'b0, v.e_b1});
        checkOutput($sformatf("v%0d busy2", idx), {31'b0, busy2_o}, {31'b0, v.e_b2});
        checkOutput($sformatf("v%0d pend_cnt", idx), {26'b0, pend_cnt_o}, {26'b0, v.e_cnt});
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //             rst we wa  wd            re1 a1 re2 a2 iwe ia  rd1                      rd2                      b1    b2    cnt
        vecs.push_back(mk(1, 1, 5, 32'h1234,     1, 5, 1, 5, 0, 0,  32'h0,                   32'h0,                   0,    0,    0));
        vecs.push_back(mk(0, 1, 5, 32'h1234,     1, 6, 0, 0, 0, 0,  32'h0,                   32'h0,                   0,    0,    0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 5, 1, 5, 0, 0,  32'h1234,                32'h1234,                0,    0,    0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 5, 0, 0, 0, 0,  32'h0,                   32'h0,                   0,    0,    0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 5, 0, 0, 0, 0,  32'h0,                   32'h0,                   0,    0,    0));
        vecs.push_back(mk(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 1, 0,  32'h0,                   32'h0,                   0,    0,    0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 0, 1, 0, 0, 0,  32'h0,                   32'h0,                   0,    0,    0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 1, 3,  32'h0,                   32'h0,                   0,    0,    0));
        vecs.push_back(mk(0, 1, 3, 32'hA5A5A5A5, 1, 3, 1, 3, 0, 0,  BYP ? 32'hA5A5A5A5 : 0, BYP ? 32'hA5A5A5A5 : 0, !BYP, !BYP, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 3, 1, 3, 0, 0,  32'hA5A5A5A5,            32'hA5A5A5A5,            0,    0,    0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 7, 0, 0, 1, 7,  32'h0,                   32'h0,                   0,    0,    0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 7, 0, 0, 0, 0,  32'h0,                   32'h0,                   1,    0,    1));
        vecs.push_back(mk(0, 1, 7, 32'h77,       1, 7, 0, 0, 0, 0,  BYP ? 32'h77 : 0,        32'h0,                   !BYP, 0,    1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 7, 0, 0, 0, 0,  32'h77,                  32'h0,                   0,    0,    0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 1, 9,  32'h0,                   32'h0,                   0,    0,    0));
        vecs.push_back(mk(0, 1, 9, 32'h99,       0, 0, 1, 9, 1, 9,  32'h0,                   BYP ? 32'h99 : 0,        0,    !BYP, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 9, 1, 9, 0, 0,  32'h99,                  32'h99,                  1,    1,    1));
        vecs.push_back(mk(0, 1, 9, 32'h9A,       1, 10, 0, 0, 1, 10, 32'h0,                  32'h0,                   0,    0,    1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 9, 1, 10, 0, 0, 32'h9A,                  32'h0,                   0,    1,    1));
        vecs.push_back(mk(0, 1, 12, 32'hC,       0, 0, 0, 0, 1, 10, 32'h0,                   32'h0,                   0,    0,    1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 12, 1, 10, 0, 0, 32'hC,                  32'h0,                   0,    1,    1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 10, 0, 12, 0, 0, 32'h0,                  32'h0,                   0,    0,    1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 1, 4,  32'h0,                   32'h0,                   0,    0,    1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 1, 6,  32'h0,                   32'h0,                   0,    0,    2));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 1, 8,  32'h0,                   32'h0,                   0,    0,    3));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 4, 0, 0, 1, 2,  32'h0,                   32'h0,                   1,    0,    4));
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 2, 1, 4, 1, 2,  32'h0,                   32'h0,                   0,    0,    5));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 2, 1, 10, 0, 0, 32'h0,                   32'h0,                   0,    0,    0));

        applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkVec(i, vecs[i]);
        end

        // Fill every register's pending bit, then drain them, tracking the counter at each step
        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'(a), 0, 0, 0, 0, 0));
            #1;
            checkOutput($sformatf("fill%0d pend_cnt", a), {26'b0, pend_cnt_o}, 32'(a - 1));
        end
        @(negedge clk);
        applyStimulus(mk(0, 0, 0, 0, 1, 31, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        #1;
        checkOutput("full pend_cnt", {26'b0, pend_cnt_o}, 32'd31);
        checkOutput("full busy1", {31'b0, busy1_o}, 32'd1);
        checkOutput("full busy2", {31'b0, busy2_o}, 32'd1);

        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            applyStimulus(mk(0, 1, 5'(a), 32'h100 + 32'(a), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            #1;
            checkOutput($sformatf("drain%0d pend_cnt", a), {26'b0, pend_cnt_o}, 32'(32 - a));
        end
        @(negedge clk);
        applyStimulus(mk(0, 0, 0, 0, 1, 17, 1, 31, 0, 0, 0, 0, 0, 0, 0));
        #1;
        checkOutput("empty pend_cnt", {26'b0, pend_cnt_o}, 32'd0);
        checkOutput("drain rdata1", rdata1, 32'h111);
        checkOutput("drain rdata2", rdata2, 32'h11F);
        checkOutput("empty busy1", {31'b0, busy1_o}, 32'd0);
        checkOutput("empty busy2", {31'b0, busy2_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
